i2s_duplex: RTL and testbench
=============================

I2S_DUPLEX -- requirements
Module: i2s_duplex

Interface
REQ-001 Parameter DATA_W, default 24, meaning audio word width per channel; legal range 8..SLOT_W-1.
REQ-002 Parameter SLOT_W, default 32, meaning bck periods per channel slot; frame = 2*SLOT_W bck.
REQ-003 Parameter DIV_LOG2, default 1, meaning bck period = 2^(DIV_LOG2+1) clk cycles (default clk/4).
REQ-004 Port: clk  input  1  system clock; one clock domain.
REQ-005 Port: reset  input  1  asynchronous, active-low reset.
REQ-006 Port: en  input  1  run enable; low idles the link.
REQ-007 Port: din  input  1  serial data from ADC.
REQ-008 Ports: bck, lrck, scki, dout  output  1 each  bit clock, word select (low = left), system clock (= clk), serial data to DAC.
REQ-009 Ports: rx_left, rx_right  output  DATA_W each  last received words; rx_valid  output  1  new-pair strobe.
REQ-010 Ports: tx_left, tx_right  input  DATA_W each; tx_valid  input  1; tx_ready  output  1  transmit handshake.
REQ-011 Ports: tx_underrun  output  1  underrun strobe; tx_underrun_cnt  output  16  underrun count.

Function
REQ-012 Prescaler p counts clk cycles 0..(2*SLOT_W*2^(DIV_LOG2+1))-1 and wraps to 0; bck = p[DIV_LOG2]; slot bit index b = bck count modulo SLOT_W; lrck = 1 during second slot.
REQ-013 en low: p held at 0, bck/lrck/dout = 0, rx_valid = 0; on en rising, the first frame starts at p = 0 (left slot, b = 0).
REQ-014 RX samples din on the clk cycle where bck rises (p low field == 2^DIV_LOG2), for b = 1..DATA_W, MSB first; I2S one-bit delay; bits at b = 0 and b > DATA_W are ignored.
REQ-015 First clk cycle after right-slot bit b = DATA_W is sampled: rx_left/rx_right load both shift registers, and rx_valid is high for exactly one clk cycle; rx outputs hold otherwise.
REQ-016 TX changes dout on the clk cycle where bck falls (p low field == 0): at b = 1..DATA_W drive active word bit DATA_W-b (MSB first); otherwise dout = 0.
REQ-017 One-entry holding buffer: tx_ready = buffer empty; tx_valid && tx_ready loads tx_left/tx_right and fills the buffer; tx_valid without tx_ready has no effect.
REQ-018 At frame start (p == 0 with en high), a full buffer moves to the active words and empties; an empty buffer loads zeros into the active words and pulses tx_underrun for one cycle.
REQ-019 Frame start and a handshake in the same cycle: the load uses the pre-edge buffer state; the accepted pair stays in the buffer for the next frame; an underrun is still flagged if the buffer was empty.
REQ-020 The buffer accepts writes while en is low; no underrun is flagged while en is low.

Reset
REQ-021 Reset assertion clears p, bck, lrck, dout, rx_left, rx_right, rx_valid, tx_underrun, tx_underrun_cnt, active words and buffer immediately; tx_ready = 1.
REQ-022 Reset mid-frame discards partial RX/TX words; after release the first frame begins at p = 0.

Configuration
REQ-023 Macro I2S_DUPLEX_STATUS_EN defined: tx_underrun_cnt increments on each tx_underrun and saturates at 16'hFFFF.
REQ-024 Macro not defined: tx_underrun_cnt is constant 0; the tx_underrun strobe is unchanged.

Structure
REQ-025 Package i2s_pkg holds SLOT_W default, DIV_LOG2 default, the 16-bit counter width, and the frame-phase strobe type.
REQ-026 Sub-module i2s_clkgen generates p, bck, lrck, b, the bck rise/fall strobes and the frame-start strobe; RX and TX datapaths stay in i2s_duplex.

Verification
REQ-027 Reset, en = 1, defaults: bck toggles every 2 clk cycles; lrck period = 256 clk cycles; first lrck rise at clk 128.
REQ-028 din drives left 24'hA5F00F and right 24'h123456 in I2S format: one rx_valid pulse per frame with rx_left = 24'hA5F00F and rx_right = 24'h123456.
REQ-029 Write tx pair 24'h800001/24'h7FFFFE before frame start: dout serializes both words MSB first at b = 1..24; tx_ready returns to 1 at the frame start.
REQ-030 No tx write for 3 frames: dout is all zeros, 3 tx_underrun pulses; tx_underrun_cnt = 3 with I2S_DUPLEX_STATUS_EN, 0 without.
REQ-031 tx handshake in the exact frame-start cycle with the buffer empty: underrun flagged; the word appears in the following frame.
REQ-032 Reset asserted at p = 77 mid-left-slot: all outputs clear asynchronously; after release no rx_valid until a full new frame completes.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S duplex link.
package i2s_pkg;

    localparam int unsigned SLOT_W_DEF   = 32;
    localparam int unsigned DIV_LOG2_DEF = 1;
    localparam int unsigned CNT_W        = 16;

    typedef struct packed {
        logic frame_start;
        logic bck_rise;
        logic bck_fall;
    } phase_strb_t;

endpackage

// File: rtl/i2s_clkgen.sv
// Frame timing for the I2S link: prescaler, bit clock, word select, slot bit index and
// the phase strobes the datapaths act on.
module i2s_clkgen
    import i2s_pkg::*;
#(
    parameter int unsigned SLOT_W   = SLOT_W_DEF,
    parameter int unsigned DIV_LOG2 = DIV_LOG2_DEF
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      en_i,
    output logic                      bck_o,
    output logic                      lrck_o,
    output logic [$clog2(SLOT_W)-1:0] bit_o,
    output phase_strb_t               strb_o
);

    localparam int unsigned LOW_W = DIV_LOG2 + 1;
    localparam int unsigned BIT_W = $clog2(SLOT_W);
    localparam int unsigned P_W   = $clog2(2 * SLOT_W) + LOW_W;

    logic [LOW_W-1:0] low_q, low_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic             slot_q, slot_d;
    logic [P_W-1:0]   p;

    // Counters are kept split so SLOT_W need not be a power of two; p is their flat view.
    assign p = (((slot_q ? P_W'(SLOT_W) : '0) + P_W'(bit_q)) << LOW_W) | P_W'(low_q);

    always_comb begin
        low_d  = low_q;
        bit_d  = bit_q;
        slot_d = slot_q;
        if (!en_i) begin
            low_d  = '0;
            bit_d  = '0;
            slot_d = 1'b0;
        end else begin
            low_d = low_q + 1'b1;
            if (&low_q) begin
                if (bit_q == BIT_W'(SLOT_W - 1)) begin
                    bit_d  = '0;
                    slot_d = ~slot_q;
                end else begin
                    bit_d = bit_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            low_q  <= '0;
            bit_q  <= '0;
            slot_q <= 1'b0;
        end else begin
            low_q  <= low_d;
            bit_q  <= bit_d;
            slot_q <= slot_d;
        end
    end

    assign bck_o  = en_i & low_q[DIV_LOG2];
    assign lrck_o = en_i & slot_q;
    assign bit_o  = bit_q;

    always_comb begin
        strb_o.bck_rise    = en_i && (low_q == LOW_W'(1 << DIV_LOG2));
        strb_o.bck_fall    = en_i && (low_q == '0);
        strb_o.frame_start = en_i && (p == '0);
    end

endmodule

// File: rtl/i2s_duplex.sv
// Full-duplex I2S master: ADC receive path, DAC transmit path with a one-pair holding buffer.
// Define I2S_DUPLEX_STATUS_EN to enable the saturating transmit underrun counter.
module i2s_duplex
    import i2s_pkg::*;
#(
    parameter int unsigned DATA_W   = 24,
    parameter int unsigned SLOT_W   = SLOT_W_DEF,
    parameter int unsigned DIV_LOG2 = DIV_LOG2_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              din_i,
    output logic              bck_o,
    output logic              lrck_o,
    output logic              scki_o,
    output logic              dout_o,
    output logic [DATA_W-1:0] rx_left_o,
    output logic [DATA_W-1:0] rx_right_o,
    output logic              rx_valid_o,
    input  logic [DATA_W-1:0] tx_left_i,
    input  logic [DATA_W-1:0] tx_right_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic              tx_underrun_o,
    output logic [CNT_W-1:0]  tx_underrun_cnt_o
);

    localparam int unsigned BIT_W = $clog2(SLOT_W);
    localparam logic [BIT_W-1:0] LastBit = BIT_W'(DATA_W);

    logic [BIT_W-1:0] bit_idx;
    logic             slot;
    phase_strb_t      strb;
    logic             in_word;

    i2s_clkgen #(
        .SLOT_W   (SLOT_W),
        .DIV_LOG2 (DIV_LOG2)
    ) u_clkgen (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (en_i),
        .bck_o  (bck_o),
        .lrck_o (slot),
        .bit_o  (bit_idx),
        .strb_o (strb)
    );

    logic [DATA_W-1:0] rx_sh_l_q, rx_sh_l_d, rx_sh_r_q, rx_sh_r_d;
    logic [DATA_W-1:0] rx_left_q, rx_left_d, rx_right_q, rx_right_d;
    logic              rx_valid_q, rx_valid_d;
    logic [DATA_W-1:0] act_l_q, act_l_d, act_r_q, act_r_d;
    logic [DATA_W-1:0] buf_l_q, buf_l_d, buf_r_q, buf_r_d;
    logic              buf_full_q, buf_full_d;
    logic              dout_q, dout_d;
    logic              underrun_q, underrun_d;

    assign in_word = (bit_idx != '0) && (bit_idx <= LastBit);

    always_comb begin
        rx_sh_l_d  = rx_sh_l_q;
        rx_sh_r_d  = rx_sh_r_q;
        rx_left_d  = rx_left_q;
        rx_right_d = rx_right_q;
        rx_valid_d = 1'b0;
        act_l_d    = act_l_q;
        act_r_d    = act_r_q;
        buf_l_d    = buf_l_q;
        buf_r_d    = buf_r_q;
        buf_full_d = buf_full_q;
        dout_d     = dout_q;
        underrun_d = 1'b0;

        if (strb.bck_rise && in_word) begin
            if (slot) begin
                rx_sh_r_d = {rx_sh_r_q[DATA_W-2:0], din_i};
            end else begin
                rx_sh_l_d = {rx_sh_l_q[DATA_W-2:0], din_i};
            end
            if (slot && (bit_idx == LastBit)) begin
                rx_left_d  = rx_sh_l_q;
                rx_right_d = {rx_sh_r_q[DATA_W-2:0], din_i};
                rx_valid_d = 1'b1;
            end
        end

        // Active words are shifted out MSB first, so the MSB always holds the next bit.
        if (!en_i) begin
            dout_d = 1'b0;
        end else if (strb.bck_fall) begin
            dout_d = 1'b0;
            if (in_word) begin
                if (slot) begin
                    dout_d  = act_r_q[DATA_W-1];
                    act_r_d = act_r_q << 1;
                end else begin
                    dout_d  = act_l_q[DATA_W-1];
                    act_l_d = act_l_q << 1;
                end
            end
        end

        // Frame start always falls on slot bit 0, so it never collides with the shift above.
        if (strb.frame_start) begin
            if (buf_full_q) begin
                act_l_d    = buf_l_q;
                act_r_d    = buf_r_q;
                buf_full_d = 1'b0;
            end else begin
                act_l_d    = '0;
                act_r_d    = '0;
                underrun_d = 1'b1;
            end
        end

        if (tx_valid_i && !buf_full_q) begin
            buf_l_d    = tx_left_i;
            buf_r_d    = tx_right_i;
            buf_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_sh_l_q  <= '0;
            rx_sh_r_q  <= '0;
            rx_left_q  <= '0;
            rx_right_q <= '0;
            rx_valid_q <= 1'b0;
            act_l_q    <= '0;
            act_r_q    <= '0;
            buf_l_q    <= '0;
            buf_r_q    <= '0;
            buf_full_q <= 1'b0;
            dout_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            rx_sh_l_q  <= rx_sh_l_d;
            rx_sh_r_q  <= rx_sh_r_d;
            rx_left_q  <= rx_left_d;
            rx_right_q <= rx_right_d;
            rx_valid_q <= rx_valid_d;
            act_l_q    <= act_l_d;
            act_r_q    <= act_r_d;
            buf_l_q    <= buf_l_d;
            buf_r_q    <= buf_r_d;
            buf_full_q <= buf_full_d;
            dout_q     <= dout_d;
            underrun_q <= underrun_d;
        end
    end

`ifdef I2S_DUPLEX_STATUS_EN
    logic [CNT_W-1:0] ur_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ur_cnt_q <= '0;
        end else if (underrun_d && !(&ur_cnt_q)) begin
            ur_cnt_q <= ur_cnt_q + 1'b1;
        end
    end

    assign tx_underrun_cnt_o = ur_cnt_q;
`else
    assign tx_underrun_cnt_o = '0;
`endif

    assign lrck_o        = slot;
    assign scki_o        = clk_i;
    assign dout_o        = en_i & dout_q;
    assign rx_left_o     = rx_left_q;
    assign rx_right_o    = rx_right_q;
    assign rx_valid_o    = en_i & rx_valid_q;
    assign tx_ready_o    = ~buf_full_q;
    assign tx_underrun_o = underrun_q;

endmodule

// File: tb/tb_i2s_duplex.sv
// Self-checking bench for i2s_duplex with default parameters against a frame-level model.
module tb_i2s_duplex;

    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          en = 1'b0;
    logic          din = 1'b0;
    logic          tx_valid = 1'b0;
    logic [DW-1:0] tx_l = '0;
    logic [DW-1:0] tx_r = '0;

    logic          bck, lrck, scki, dout, rx_valid, tx_ready, tx_underrun;
    logic [DW-1:0] rx_left, rx_right;
    logic [15:0]   ur_cnt;

    always #5 clk = ~clk;

    i2s_duplex dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .en_i              (en),
        .din_i             (din),
        .bck_o             (bck),
        .lrck_o            (lrck),
        .scki_o            (scki),
        .dout_o            (dout),
        .rx_left_o         (rx_left),
        .rx_right_o        (rx_right),
        .rx_valid_o        (rx_valid),
        .tx_left_i         (tx_l),
        .tx_right_i        (tx_r),
        .tx_valid_i        (tx_valid),
        .tx_ready_o        (tx_ready),
        .tx_underrun_o     (tx_underrun),
        .tx_underrun_cnt_o (ur_cnt)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Frame-level reference state; mp is the prescaler value of the current cycle.
    int unsigned   mp, mfr, exp_cnt;
    logic          m_full, exp_dout, exp_rxv, exp_ur;
    logic [DW-1:0] m_buf_l, m_buf_r, m_act_l, m_act_r, exp_rxl, exp_rxr;
    logic [DW-1:0] rxw_l[64];
    logic [DW-1:0] rxw_r[64];

    function automatic logic din_for(int unsigned p, int unsigned fr);
        int unsigned b, s;
        b = (p >> 2) % 32;
        s = (p >> 7) & 1;
        if (b >= 1 && b <= DW) return s ? rxw_r[fr % 64][DW-b] : rxw_l[fr % 64][DW-b];
        return 1'($urandom);
    endfunction

    task automatic model_clear();
        mp = 0; mfr = 0; exp_cnt = 0;
        m_full = 0; exp_dout = 0; exp_rxv = 0; exp_ur = 0;
        m_buf_l = '0; m_buf_r = '0; m_act_l = '0; m_act_r = '0;
        exp_rxl = '0; exp_rxr = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = 1'b0;
        tx_valid = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        din = din_for(0, 0);
    endtask

    // Advance one clock: update the model for this edge from the current inputs, then
    // sample point is #1 after the edge.
    task automatic tick();
        int unsigned b, s;
        logic fs, acc;
        b = (mp >> 2) % 32;
        s = (mp >> 7) & 1;
        fs = en && (mp == 0);
        acc = tx_valid && !m_full;
        exp_rxv = 0;
        exp_ur = 0;
        if (!en) begin
            exp_dout = 0;
        end else begin
            if (mp % 4 == 0) exp_dout = (b >= 1 && b <= DW) ? (s ? m_act_r[DW-b] : m_act_l[DW-b]) : 1'b0;
            if (mp % 4 == 2 && s == 1 && b == DW) begin
                exp_rxv = 1;
                exp_rxl = rxw_l[mfr % 64];
                exp_rxr = rxw_r[mfr % 64];
            end
        end
        if (fs) begin
            if (m_full) begin
                m_act_l = m_buf_l; m_act_r = m_buf_r; m_full = 0;
            end else begin
                m_act_l = '0; m_act_r = '0; exp_ur = 1;
`ifdef I2S_DUPLEX_STATUS_EN
                if (exp_cnt < 65535) exp_cnt++;
`endif
            end
        end
        if (acc) begin
            m_buf_l = tx_l; m_buf_r = tx_r; m_full = 1;
        end
        if (en) begin
            mp = (mp + 1) % 256;
            if (mp == 0) mfr++;
        end else begin
            mp = 0;
        end
        @(posedge clk);
        #1;
        din = din_for(mp, mfr);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_chk += 3;
        if ({bck, lrck, dout, rx_valid, tx_underrun, tx_ready} !== 6'b000001) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 000001",
                     {bck, lrck, dout, rx_valid, tx_underrun, tx_ready});
        end
        if ({rx_left, rx_right} !== '0) begin
            n_fail++; $display("FAIL reset_rx: got %h/%h want 0/0", rx_left, rx_right);
        end
        if (ur_cnt !== 16'h0) begin
            n_fail++; $display("FAIL reset_cnt: got %h want 0", ur_cnt);
        end
        do_reset();
    endtask

    task automatic test_clocks();
        int first;
        logic prev;
        do_reset();
        en = 1'b1;
        first = -1;
        prev = 1'b0;
        for (int t = 1; t <= 512; t++) begin
            tick();
            n_chk += 2;
            if (bck !== 1'((mp >> 1) & 1)) begin
                n_fail++; $display("FAIL bck t=%0d: got %b want %b", t, bck, (mp >> 1) & 1);
            end
            if (lrck !== 1'((mp >> 7) & 1)) begin
                n_fail++; $display("FAIL lrck t=%0d: got %b want %b", t, lrck, (mp >> 7) & 1);
            end
            if (lrck && !prev && first < 0) first = t;
            prev = lrck;
        end
        n_chk += 2;
        if (first != 128) begin
            n_fail++; $display("FAIL lrck_first_rise: got %0d want 128", first);
        end
        if (scki !== 1'b1) begin
            n_fail++; $display("FAIL scki: got %b want 1 just after rising clk", scki);
        end
    endtask

    task automatic test_rx();
        int pulses;
        do_reset();
        en = 1'b1;
        pulses = 0;
        for (int t = 0; t < 3 * 256; t++) begin
            tick();
            n_chk += 3;
            if (rx_valid !== exp_rxv) begin
                n_fail++; $display("FAIL rx_valid p=%0d: got %b want %b", mp, rx_valid, exp_rxv);
            end
            if (rx_left !== exp_rxl) begin
                n_fail++; $display("FAIL rx_left p=%0d: got %h want %h", mp, rx_left, exp_rxl);
            end
            if (rx_right !== exp_rxr) begin
                n_fail++; $display("FAIL rx_right p=%0d: got %h want %h", mp, rx_right, exp_rxr);
            end
            if (rx_valid === 1'b1) pulses++;
        end
        n_chk++;
        if (pulses != 3) begin
            n_fail++; $display("FAIL rx_pulses: got %0d want 3", pulses);
        end
    endtask

    task automatic test_tx();
        int unsigned wr_at, b, s;
        logic [DW-1:0] cap_l, cap_r;
        do_reset();
        tx_l = 24'h800001;
        tx_r = 24'h7FFFFE;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        n_chk++;
        if (tx_ready !== 1'b0) begin
            n_fail++; $display("FAIL tx_ready_en_low: got %b want 0", tx_ready);
        end
        en = 1'b1;
        cap_l = '0;
        cap_r = '0;
        wr_at = 0;
        for (int t = 0; t < 6 * 256; t++) begin
            if (mp == 0) wr_at = $urandom_range(1, 200);
            if (mfr != 2 && mp == wr_at) begin
                tx_valid = 1'b1; tx_l = DW'($urandom); tx_r = DW'($urandom);
            end else if (mfr != 2 && mp == wr_at + 5) begin
                tx_valid = 1'b1; tx_l = DW'($urandom); tx_r = DW'($urandom);
            end
            tick();
            tx_valid = 1'b0;
            if (t == 0) begin
                n_chk++;
                if (tx_ready !== 1'b1) begin
                    n_fail++; $display("FAIL tx_ready_frame_start: got %b want 1", tx_ready);
                end
            end
            if (mfr == 0 && mp % 4 == 1) begin
                b = ((mp - 1) >> 2) % 32;
                s = ((mp - 1) >> 7) & 1;
                if (b >= 1 && b <= DW) begin
                    if (s == 1) cap_r[DW-b] = dout; else cap_l[DW-b] = dout;
                end
            end
            n_chk += 3;
            if (dout !== exp_dout) begin
                n_fail++; $display("FAIL tx_dout f=%0d p=%0d: got %b want %b", mfr, mp, dout, exp_dout);
            end
            if (tx_ready !== !m_full) begin
                n_fail++; $display("FAIL tx_ready p=%0d: got %b want %b", mp, tx_ready, !m_full);
            end
            if (tx_underrun !== exp_ur) begin
                n_fail++; $display("FAIL tx_underrun p=%0d: got %b want %b", mp, tx_underrun, exp_ur);
            end
        end
        n_chk += 2;
        if (cap_l !== 24'h800001) begin
            n_fail++; $display("FAIL tx_word_left: got %h want 800001", cap_l);
        end
        if (cap_r !== 24'h7FFFFE) begin
            n_fail++; $display("FAIL tx_word_right: got %h want 7ffffe", cap_r);
        end
    endtask

    task automatic test_underrun();
        int ur;
        do_reset();
        en = 1'b1;
        ur = 0;
        for (int t = 0; t < 3 * 256; t++) begin
            tick();
            n_chk += 2;
            if (dout !== 1'b0) begin
                n_fail++; $display("FAIL ur_dout p=%0d: got %b want 0", mp, dout);
            end
            if (tx_underrun !== exp_ur) begin
                n_fail++; $display("FAIL ur_strobe p=%0d: got %b want %b", mp, tx_underrun, exp_ur);
            end
            if (tx_underrun === 1'b1) ur++;
        end
        n_chk += 2;
        if (ur != 3) begin
            n_fail++; $display("FAIL ur_pulses: got %0d want 3", ur);
        end
`ifdef I2S_DUPLEX_STATUS_EN
        if (ur_cnt !== 16'd3) begin
            n_fail++; $display("FAIL ur_cnt: got %0d want 3", ur_cnt);
        end
`else
        if (ur_cnt !== 16'd0) begin
            n_fail++; $display("FAIL ur_cnt: got %0d want 0", ur_cnt);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int unsigned b, s;
        logic [DW-1:0] wl, wr, cap_l, cap_r;
        do_reset();
        en = 1'b1;
        for (int t = 0; t < 256; t++) tick();
        wl = DW'($urandom);
        wr = DW'($urandom);
        tx_l = wl;
        tx_r = wr;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        n_chk += 2;
        if (tx_underrun !== 1'b1) begin
            n_fail++; $display("FAIL b2b_underrun: got %b want 1", tx_underrun);
        end
        if (tx_ready !== 1'b0) begin
            n_fail++; $display("FAIL b2b_ready: got %b want 0", tx_ready);
        end
        cap_l = '0;
        cap_r = '0;
        for (int t = 0; t < 511; t++) begin
            tick();
            n_chk++;
            if (dout !== exp_dout) begin
                n_fail++; $display("FAIL b2b_dout f=%0d p=%0d: got %b want %b", mfr, mp, dout, exp_dout);
            end
            if (mfr == 2 && mp % 4 == 1) begin
                b = ((mp - 1) >> 2) % 32;
                s = ((mp - 1) >> 7) & 1;
                if (b >= 1 && b <= DW) begin
                    if (s == 1) cap_r[DW-b] = dout; else cap_l[DW-b] = dout;
                end
            end
        end
        n_chk += 2;
        if (cap_l !== wl) begin
            n_fail++; $display("FAIL b2b_word_left: got %h want %h", cap_l, wl);
        end
        if (cap_r !== wr) begin
            n_fail++; $display("FAIL b2b_word_right: got %h want %h", cap_r, wr);
        end
    endtask

    task automatic test_reset_mid();
        int first;
        do_reset();
        en = 1'b1;
        tx_l = DW'($urandom);
        tx_r = DW'($urandom);
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        while (mp != 77) tick();
        #2 rst_n = 1'b0;
        #1;
        n_chk += 3;
        if ({bck, lrck, dout, rx_valid, tx_underrun, tx_ready} !== 6'b000001) begin
            n_fail++;
            $display("FAIL midrst_ctrl: got %b want 000001",
                     {bck, lrck, dout, rx_valid, tx_underrun, tx_ready});
        end
        if ({rx_left, rx_right} !== '0) begin
            n_fail++; $display("FAIL midrst_rx: got %h/%h want 0/0", rx_left, rx_right);
        end
        if (ur_cnt !== 16'h0) begin
            n_fail++; $display("FAIL midrst_cnt: got %h want 0", ur_cnt);
        end
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        din = din_for(0, 0);
        first = -1;
        for (int t = 1; t <= 300; t++) begin
            tick();
            n_chk++;
            if (rx_valid !== exp_rxv) begin
                n_fail++; $display("FAIL midrst_rxv p=%0d: got %b want %b", mp, rx_valid, exp_rxv);
            end
            if (rx_valid === 1'b1 && first < 0) first = t;
        end
        n_chk++;
        if (first != 227) begin
            n_fail++; $display("FAIL midrst_first_valid: got %0d want 227", first);
        end
    endtask

    initial begin
        rxw_l[0] = 24'hA5F00F;
        rxw_r[0] = 24'h123456;
        for (int i = 1; i < 64; i++) begin
            rxw_l[i] = DW'($urandom);
            rxw_r[i] = DW'($urandom);
        end
        model_clear();
        test_reset();
        test_clocks();
        test_rx();
        test_tx();
        test_underrun();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
